// File: rtl/rosco_busctl.sv
// rosco_busctl: 68k bus-cycle controller with per-region wait-state DTACK, ext-DTACK pass-through and BERR watchdog (optional ROSCO_BUSCTL_SYNC_EN input synchronisers)
module rosco_busctl #(
  parameter int NREG = 4,
  parameter int WSW  = 4,
  parameter int WDW  = 7,
  parameter int ECW  = 8
) (
  input  logic                 CLK,
  input  logic                 RESETn,
  input  logic                 ASn,
  input  logic                 DSn,
  input  logic                 cpusp,
  input  logic [NREG-1:0]      region_sel,
  input  logic [NREG*WSW-1:0]  ws_cfg,
  input  logic                 ext_dtackn,
  output logic                 DTACKn,
  output logic                 BERRn,
  output logic                 busy,
  output logic [ECW-1:0]       err_cnt
);
  localparam logic [2:0] S_IDLE = 3'd0, S_WAIT = 3'd1, S_EXT = 3'd2,
                         S_ACK  = 3'd3, S_BERR = 3'd4, S_DONE = 3'd5;
  localparam logic [WDW-1:0] WD_LAST = {{(WDW-1){1'b1}}, 1'b0};
  logic as_n, ds_n, ext_n;
`ifdef ROSCO_BUSCTL_SYNC_EN
  logic [2:0] sync1_q, sync2_q;
  always_ff @(posedge CLK or negedge RESETn)
    if (!RESETn) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= {ASn, DSn, ext_dtackn};
      sync2_q <= sync1_q;
    end
  assign {as_n, ds_n, ext_n} = sync2_q;
`else
  assign {as_n, ds_n, ext_n} = {ASn, DSn, ext_dtackn};
`endif
  logic [2:0]     state_q, state_d;
  logic [WSW-1:0] wcnt_q, wcnt_d, ws_sel;
  logic [WDW-1:0] wd_q, wd_d;
  logic [ECW-1:0] err_q, err_d;
  logic           dtackn_q, dtackn_d, berrn_q, berrn_d, busy_q, busy_d;
  // descending scan so the lowest set region index is the one left standing
  always_comb begin
    ws_sel = '0;
    for (int i = NREG - 1; i >= 0; i--)
      if (region_sel[i]) ws_sel = ws_cfg[i*WSW +: WSW];
  end
  // wd_q == WD_LAST means this edge takes the watchdog to all-ones
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      S_IDLE: if (!as_n && !ds_n) begin
        state_d = (!cpusp && |region_sel) ? S_WAIT : S_EXT;
        wcnt_d  = ws_sel;
      end
      S_WAIT: if (as_n) state_d = S_IDLE;
        else if (wcnt_q == '0) state_d = S_ACK;
        else begin
          wcnt_d  = wcnt_q - 1'b1;
          state_d = (wd_q == WD_LAST) ? S_BERR : S_WAIT;
        end
      S_EXT: state_d = as_n ? S_IDLE : !ext_n ? S_DONE : (wd_q == WD_LAST) ? S_BERR : S_EXT;
      S_ACK, S_BERR, S_DONE: state_d = as_n ? S_IDLE : state_q;
      default: state_d = S_IDLE;
    endcase
    wd_d     = (state_d == state_q && (state_q == S_WAIT || state_q == S_EXT)) ? wd_q + 1'b1 : '0;
    err_d    = (state_d == S_BERR && state_q != S_BERR && ~&err_q) ? err_q + 1'b1 : err_q;
    dtackn_d = state_d != S_ACK;
    berrn_d  = state_d != S_BERR;
    busy_d   = state_d != S_IDLE;
  end
  always_ff @(posedge CLK or negedge RESETn)
    if (!RESETn) begin
      state_q  <= S_IDLE;
      wcnt_q   <= '0;
      wd_q     <= '0;
      err_q    <= '0;
      dtackn_q <= 1'b1;
      berrn_q  <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      wd_q     <= wd_d;
      err_q    <= err_d;
      dtackn_q <= dtackn_d;
      berrn_q  <= berrn_d;
      busy_q   <= busy_d;
    end
  assign DTACKn  = dtackn_q;
  assign BERRn   = berrn_q;
  assign busy    = busy_q;
  assign err_cnt = err_q;
endmodule

// File: tb/tb_rosco_busctl.sv
// tb_rosco_busctl: table-driven and randomized transaction checks of rosco_busctl against a cycle-outcome model
module tb_rosco_busctl;
  localparam int TMO = 127;
  logic        CLK, RESETn, ASn, DSn, cpusp, ext_dtackn;
  logic [3:0]  region_sel;
  logic [15:0] ws_cfg;
  logic        DTACKn, BERRn, busy;
  logic [7:0]  err_cnt;
  int n_vec, n_err, err_m;

  rosco_busctl dut (
    .CLK(CLK), .RESETn(RESETn), .ASn(ASn), .DSn(DSn), .cpusp(cpusp),
    .region_sel(region_sel), .ws_cfg(ws_cfg), .ext_dtackn(ext_dtackn),
    .DTACKn(DTACKn), .BERRn(BERRn), .busy(busy), .err_cnt(err_cnt)
  );

  initial CLK = 0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0]  rsel;
    logic [15:0] ws;
    logic        cp;
    int          d;
    int          a;
    int          kind;
    int          lat;
  } vec_t;
  vec_t tbl[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, "_dtackn"}, DTACKn, 1);
    chk({nm, "_berrn"}, BERRn, 1);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_err"}, err_cnt, err_m);
  endtask

  // kind: 0 abort, 1 internal DTACK, 2 external DTACK, 3 bus error; lat = edges after start
  function automatic void model(input logic [3:0] rsel, input logic [15:0] ws, input logic cp,
                                input int d, input int a, output int kind, output int lat);
    int w;
    w = -1;
    for (int i = 0; i < 4; i++)
      if (w < 0 && rsel[i]) w = int'(ws[i*4 +: 4]);
    if (!cp && w >= 0) begin
      lat  = 1 + w;
      kind = (a <= lat) ? 0 : 1;
    end else begin
      lat  = TMO;
      kind = (a <= d && a <= TMO) ? 0 : (d <= TMO) ? 2 : 3;
    end
  endfunction

  task automatic run_txn(input logic [3:0] rsel, input logic [15:0] ws, input logic cp,
                         input int d, input int a, input int kind, input int lat);
    region_sel = rsel; ws_cfg = ws; cpusp = cp; ext_dtackn = 1; ASn = 0; DSn = 0;
    for (int j = 0; j <= a + 1; j++) begin
      if (j > 0) begin
        ASn = (j >= a); DSn = ASn; ext_dtackn = !(j >= d);
        region_sel = 4'($urandom); ws_cfg = 16'($urandom); cpusp = 1'($urandom);
      end
      @(posedge CLK); #1;
      if (kind == 3 && j == lat) err_m = (err_m == 255) ? 255 : err_m + 1;
      chk("dtackn", DTACKn, !(kind == 1 && j >= lat && j < a));
      chk("berrn", BERRn, !(kind == 3 && j >= lat && j < a));
      chk("busy", busy, j < a);
      chk("err_cnt", err_cnt, err_m);
    end
  endtask

  initial begin
    int k, l, d, a;
    logic [3:0]  rs;
    logic [15:0] ws;
    logic        cp;
    n_vec = 0; n_err = 0; err_m = 0;
    RESETn = 0; ASn = 1; DSn = 1; cpusp = 0; ext_dtackn = 1; region_sel = 0; ws_cfg = 0;
    tbl[0]  = '{4'b0010, 16'h0030, 1'b0, 300, 8,   1, 4};
    tbl[1]  = '{4'b0010, 16'hFF0F, 1'b0, 300, 5,   1, 1};
    tbl[2]  = '{4'b1000, 16'hF000, 1'b0, 300, 20,  1, 16};
    tbl[3]  = '{4'b0110, 16'h0920, 1'b0, 300, 10,  1, 3};
    tbl[4]  = '{4'b0000, 16'h0000, 1'b0, 10,  15,  2, 0};
    tbl[5]  = '{4'b0000, 16'h0000, 1'b0, 300, 135, 3, 127};
    tbl[6]  = '{4'b0000, 16'h0000, 1'b0, 127, 140, 2, 0};
    tbl[7]  = '{4'b0010, 16'h0030, 1'b1, 5,   9,   2, 0};
    tbl[8]  = '{4'b0010, 16'h00A0, 1'b0, 300, 4,   0, 0};
    tbl[9]  = '{4'b0001, 16'h0000, 1'b0, 300, 1,   0, 0};
    tbl[10] = '{4'b0000, 16'h0000, 1'b0, 128, 130, 3, 127};
    tbl[11] = '{4'b0000, 16'h0000, 1'b0, 300, 3,   0, 0};
    #12;
    chk_idle("reset");
    @(posedge CLK); #1;
    RESETn = 1;
    repeat (200) begin
      @(posedge CLK); #1;
      chk_idle("idle");
    end
    ASn = 0; DSn = 1;
    repeat (5) begin
      @(posedge CLK); #1;
      chk_idle("as_only");
    end
    ASn = 1;
    @(posedge CLK); #1;
    foreach (tbl[i]) run_txn(tbl[i].rsel, tbl[i].ws, tbl[i].cp, tbl[i].d, tbl[i].a, tbl[i].kind, tbl[i].lat);
    repeat (150) begin
      rs = 4'($urandom);
      ws = 16'($urandom);
      cp = ($urandom_range(0, 7) == 0);
      d  = ($urandom_range(0, 2) == 0) ? 300 : $urandom_range(1, 200);
      case ($urandom_range(0, 2))
        0: a = $urandom_range(1, 20);
        1: a = $urandom_range(20, 60);
        default: a = $urandom_range(120, 140);
      endcase
      model(rs, ws, cp, d, a, k, l);
      run_txn(rs, ws, cp, d, a, k, l);
    end
    repeat (260) run_txn(4'b0000, 16'h0000, 1'b0, 300, 130, 3, 127);
    chk("err_sat", err_cnt, 255);
    region_sel = 4'b0010; ws_cfg = 16'h00A0; cpusp = 0; ASn = 0; DSn = 0;
    repeat (4) begin
      @(posedge CLK); #1;
    end
    chk("mid_wait_busy", busy, 1);
    #2 RESETn = 0;
    err_m = 0;
    #1 chk_idle("async_reset");
    ASn = 1; DSn = 1;
    @(posedge CLK); #1;
    RESETn = 1;
    @(posedge CLK); #1;
    chk_idle("post_reset");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
